// File: rtl/flash_miso_sel_mux_if.sv
// Host SPI, flash MISO and select-control bundle for flash_miso_sel_mux.
// master = stimulus/host side, slave = the selector itself.
interface flash_miso_sel_mux_if #(
    parameter int N_FLASH = 4,
    parameter int CNT_W   = 8
);
    localparam int SEL_W = $clog2(N_FLASH);

    logic [N_FLASH-1:0] f_miso;
    logic               h_cs_n;
    logic               h_sck;
    logic [SEL_W-1:0]   sel_req;
    logic               sel_req_vld;
    logic               h_miso;
    logic [SEL_W-1:0]   sel_active;
    logic               sel_pending;
    logic               sel_err;
    logic [CNT_W-1:0]   mis_cnt;
    logic               mis_flag;

    modport master (
        output f_miso, h_cs_n, h_sck, sel_req, sel_req_vld,
        input  h_miso, sel_active, sel_pending, sel_err, mis_cnt, mis_flag
    );

    modport slave (
        input  f_miso, h_cs_n, h_sck, sel_req, sel_req_vld,
        output h_miso, sel_active, sel_pending, sel_err, mis_cnt, mis_flag
    );
endinterface

// File: rtl/flash_miso_sel_mux.sv
// Registered N-way MISO selector: flash select only changes between SPI frames.
// Define MISO_CMP_EN to add the flash 0 / flash 1 mirror-compare counter and flag.
module flash_miso_sel_mux #(
    parameter int N_FLASH     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flash_miso_sel_mux_if.slave  bus
);
    localparam int          SEL_W      = $clog2(N_FLASH);
    localparam logic [31:0] N_FLASH_U  = 32'(N_FLASH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

    logic [SYNC_STAGES-1:0]              cs_sync_q;
    logic [SYNC_STAGES-1:0][N_FLASH-1:0] miso_sync_q;
    logic                                cs_s;
    logic [N_FLASH-1:0]                  miso_s;
    logic                                cs_q;
    logic                                cs_fall_s;
    logic                                cs_rise_s;
    logic                                req_ok_s;
    logic [31:0]                         req_ext_s;
    logic [31:0]                         act_ext_s;
    logic                                sel_bit_s;
    frame_state_e                        state_q;
    logic [SEL_W-1:0]                    sel_active_q;
    logic [SEL_W-1:0]                    pend_sel_q;
    logic                                sel_pending_q;
    logic                                sel_err_q;
    logic                                h_miso_q;

    // Synchroniser chains for chip select and flash MISO lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            miso_sync_q <= '1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.h_cs_n};
            miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], bus.f_miso};
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign miso_s    = miso_sync_q[SYNC_STAGES-1];
    assign cs_fall_s = cs_q & ~cs_s;
    assign cs_rise_s = ~cs_q & cs_s;
    assign req_ext_s = {{(32-SEL_W){1'b0}}, bus.sel_req};
    assign act_ext_s = {{(32-SEL_W){1'b0}}, sel_active_q};
    assign req_ok_s  = bus.sel_req_vld & (req_ext_s < N_FLASH_U);

    // Frame FSM and select arbitration; a request coinciding with frame end wins over the queued one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cs_q          <= 1'b1;
            sel_active_q  <= '0;
            pend_sel_q    <= '0;
            sel_pending_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            cs_q      <= cs_s;
            sel_err_q <= bus.sel_req_vld & ~req_ok_s;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_q <= ST_ACTIVE;
                        if (req_ok_s) begin
                            pend_sel_q    <= bus.sel_req;
                            sel_pending_q <= 1'b1;
                        end
                    end else if (req_ok_s) begin
                        sel_active_q <= bus.sel_req;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise_s) begin
                        state_q       <= ST_IDLE;
                        sel_pending_q <= 1'b0;
                        if (req_ok_s) begin
                            sel_active_q <= bus.sel_req;
                        end else if (sel_pending_q) begin
                            sel_active_q <= pend_sel_q;
                        end
                    end else if (req_ok_s) begin
                        pend_sel_q    <= bus.sel_req;
                        sel_pending_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // MISO mux; codes beyond N_FLASH read as idle-high.
    always_comb begin
        sel_bit_s = 1'b1;
        if (act_ext_s < N_FLASH_U) begin
            sel_bit_s = miso_s[sel_active_q];
        end else begin
            sel_bit_s = 1'b1;
        end
    end

    // Registered host MISO, forced high outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_miso_q <= 1'b1;
        end else begin
            h_miso_q <= cs_s ? 1'b1 : sel_bit_s;
        end
    end

    assign bus.h_miso      = h_miso_q;
    assign bus.sel_active  = sel_active_q;
    assign bus.sel_pending = sel_pending_q;
    assign bus.sel_err     = sel_err_q;

`ifdef MISO_CMP_EN
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic                   sck_q;
    logic                   sck_rise_s;
    logic [CNT_W-1:0]       mis_cnt_q;
    logic                   mis_flag_q;

    assign sck_rise_s = sck_sync_q[SYNC_STAGES-1] & ~sck_q;

    // SCK synchroniser and flash 0 / flash 1 mirror compare on each synced rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            sck_q      <= 1'b0;
            mis_cnt_q  <= '0;
            mis_flag_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.h_sck};
            sck_q      <= sck_sync_q[SYNC_STAGES-1];
            if (cs_fall_s) begin
                mis_flag_q <= 1'b0;
            end else if ((state_q == ST_ACTIVE) && sck_rise_s && (miso_s[0] != miso_s[1])) begin
                mis_flag_q <= 1'b1;
                if (mis_cnt_q != {CNT_W{1'b1}}) begin
                    mis_cnt_q <= mis_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.mis_cnt  = mis_cnt_q;
    assign bus.mis_flag = mis_flag_q;
`else
    assign bus.mis_cnt  = '0;
    assign bus.mis_flag = 1'b0;
`endif
endmodule

// File: tb/tb_flash_miso_sel_mux.sv
// Bench for flash_miso_sel_mux (N_FLASH=3, SYNC_STAGES=2, CNT_W=2) with a frame-level reference model.
module tb_flash_miso_sel_mux;
    localparam int N     = 3;
    localparam int S     = 2;
    localparam int CW    = 2;
`ifdef MISO_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Frame-level reference model state.
    logic [1:0] m_sel;
    logic       m_pend;
    logic [1:0] m_pend_sel;
    int         m_cnt;
    logic       m_flag;

    flash_miso_sel_mux_if #(.N_FLASH(N), .CNT_W(CW)) bus ();

    flash_miso_sel_mux #(.N_FLASH(N), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] s);
        bus.sel_req     = s;
        bus.sel_req_vld = 1'b1;
        cyc(1);
        bus.sel_req_vld = 1'b0;
    endtask

    task automatic sck_pulse();
        bus.h_sck = 1'b1;
        cyc(4);
        bus.h_sck = 1'b0;
        cyc(4);
    endtask

    function automatic logic [1:0] exp_cnt();
        return CMP_EN ? 2'(m_cnt) : 2'd0;
    endfunction

    function automatic logic exp_flag();
        return CMP_EN ? m_flag : 1'b0;
    endfunction

    task automatic test_reset();
        checks++;
        if ({bus.h_miso, bus.sel_active, bus.sel_pending, bus.sel_err, bus.mis_cnt, bus.mis_flag} !== 8'b1_00_0_0_00_0) begin
            failures++;
            $display("FAIL reset_init: got %b want 10000000",
                     {bus.h_miso, bus.sel_active, bus.sel_pending, bus.sel_err, bus.mis_cnt, bus.mis_flag});
        end
        strobe(2'd2);
        bus.f_miso = 3'b000;
        bus.h_cs_n = 1'b0;
        cyc(5);
        strobe(2'd1);
        checks++;
        if (bus.sel_pending !== 1'b1) begin
            failures++; $display("FAIL reset_pend_setup: got %b want 1", bus.sel_pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.h_miso, bus.sel_active, bus.sel_pending, bus.sel_err, bus.mis_cnt, bus.mis_flag} !== 8'b1_00_0_0_00_0) begin
            failures++;
            $display("FAIL reset_midframe: got %b want 10000000",
                     {bus.h_miso, bus.sel_active, bus.sel_pending, bus.sel_err, bus.mis_cnt, bus.mis_flag});
        end
        bus.h_cs_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        checks++;
        if ({bus.h_miso, bus.sel_active, bus.sel_pending} !== 4'b1_00_0) begin
            failures++; $display("FAIL reset_release: got %b want 1000", {bus.h_miso, bus.sel_active, bus.sel_pending});
        end
        m_sel = 2'd0; m_pend = 1'b0; m_cnt = 0; m_flag = 1'b0;
    endtask

    task automatic test_idle_select();
        strobe(2'd2);
        m_sel = 2'd2;
        checks++;
        if (bus.sel_active !== 2'd2) begin
            failures++; $display("FAIL idle_sel: got %0d want 2", bus.sel_active);
        end
        bus.f_miso = 3'b000;
        bus.h_cs_n = 1'b0;
        cyc(6);
        m_flag = 1'b0;
        checks++;
        if (bus.h_miso !== 1'b0) begin
            failures++; $display("FAIL idle_miso0: got %b want 0", bus.h_miso);
        end
        bus.f_miso = 3'b100;
        cyc(S);
        checks++;
        if (bus.h_miso !== 1'b0) begin
            failures++; $display("FAIL latency_early: got %b want 0", bus.h_miso);
        end
        cyc(1);
        checks++;
        if (bus.h_miso !== 1'b1) begin
            failures++; $display("FAIL latency_exact: got %b want 1", bus.h_miso);
        end
        bus.h_cs_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_deferred_select();
        strobe(2'd0);
        m_sel = 2'd0;
        bus.h_cs_n = 1'b0;
        cyc(5);
        strobe(2'd2);
        strobe(2'd1);
        checks++;
        if ({bus.sel_pending, bus.sel_active} !== 3'b1_00) begin
            failures++; $display("FAIL defer_pend: got %b want 100", {bus.sel_pending, bus.sel_active});
        end
        bus.f_miso = 3'b110;
        cyc(4);
        checks++;
        if (bus.h_miso !== 1'b0) begin
            failures++; $display("FAIL defer_track0a: got %b want 0", bus.h_miso);
        end
        bus.f_miso = 3'b001;
        cyc(4);
        checks++;
        if (bus.h_miso !== 1'b1) begin
            failures++; $display("FAIL defer_track0b: got %b want 1", bus.h_miso);
        end
        bus.h_cs_n = 1'b1;
        cyc(2);
        checks++;
        if ({bus.sel_pending, bus.sel_active} !== 3'b1_00) begin
            failures++; $display("FAIL defer_hold: got %b want 100", {bus.sel_pending, bus.sel_active});
        end
        cyc(1);
        m_sel = 2'd1;
        checks++;
        if ({bus.sel_pending, bus.sel_active} !== 3'b0_01) begin
            failures++; $display("FAIL defer_apply: got %b want 001", {bus.sel_pending, bus.sel_active});
        end
        cyc(3);
    endtask

    task automatic test_bad_index();
        strobe(2'd3);
        checks++;
        if ({bus.sel_err, bus.sel_active} !== 3'b1_01) begin
            failures++; $display("FAIL bad_err: got %b want 101", {bus.sel_err, bus.sel_active});
        end
        cyc(1);
        checks++;
        if (bus.sel_err !== 1'b0) begin
            failures++; $display("FAIL bad_pulse: got %b want 0", bus.sel_err);
        end
        bus.h_cs_n = 1'b0;
        cyc(5);
        strobe(2'd2);
        strobe(2'd3);
        checks++;
        if ({bus.sel_err, bus.sel_pending} !== 2'b11) begin
            failures++; $display("FAIL bad_active: got %b want 11", {bus.sel_err, bus.sel_pending});
        end
        bus.h_cs_n = 1'b1;
        cyc(5);
        m_sel = 2'd2;
        checks++;
        if (bus.sel_active !== 2'd2) begin
            failures++; $display("FAIL bad_keep_pend: got %0d want 2", bus.sel_active);
        end
    endtask

    task automatic test_edge_collision();
        bus.h_cs_n = 1'b0;
        cyc(S);
        strobe(2'd0);
        checks++;
        if ({bus.sel_pending, bus.sel_active} !== 3'b1_10) begin
            failures++; $display("FAIL coll_fall: got %b want 110", {bus.sel_pending, bus.sel_active});
        end
        cyc(4);
        bus.h_cs_n = 1'b1;
        cyc(S);
        strobe(2'd1);
        m_sel = 2'd1;
        checks++;
        if ({bus.sel_pending, bus.sel_active} !== 3'b0_01) begin
            failures++; $display("FAIL coll_rise: got %b want 001", {bus.sel_pending, bus.sel_active});
        end
        cyc(3);
    endtask

    task automatic test_mismatch();
        bus.h_cs_n = 1'b0;
        cyc(5);
        m_flag = 1'b0;
        bus.f_miso = 3'b001;
        cyc(4);
        for (int i = 0; i < 5; i++) begin
            sck_pulse();
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            m_flag = 1'b1;
        end
        checks++;
        if ({bus.mis_cnt, bus.mis_flag} !== {exp_cnt(), exp_flag()}) begin
            failures++; $display("FAIL mis_sat: got %b want %b", {bus.mis_cnt, bus.mis_flag}, {exp_cnt(), exp_flag()});
        end
        bus.h_cs_n = 1'b1;
        cyc(5);
        checks++;
        if (bus.mis_flag !== exp_flag()) begin
            failures++; $display("FAIL mis_sticky: got %b want %b", bus.mis_flag, exp_flag());
        end
        bus.h_cs_n = 1'b0;
        cyc(5);
        m_flag = 1'b0;
        checks++;
        if ({bus.mis_cnt, bus.mis_flag} !== {exp_cnt(), 1'b0}) begin
            failures++; $display("FAIL mis_clear: got %b want %b", {bus.mis_cnt, bus.mis_flag}, {exp_cnt(), 1'b0});
        end
        bus.h_cs_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic [2:0] w;
        int         ops;
        for (int f = 0; f < 25; f++) begin
            r = 2'($urandom_range(0, 3));
            strobe(r);
            if (r < 2'd3) m_sel = r;
            checks++;
            if ({bus.sel_active, bus.sel_err} !== {m_sel, (r == 2'd3)}) begin
                failures++; $display("FAIL rnd_idle f=%0d: got %b want %b", f, {bus.sel_active, bus.sel_err}, {m_sel, (r == 2'd3)});
            end
            cyc(1);
            bus.h_cs_n = 1'b0;
            cyc(5);
            m_flag = 1'b0;
            ops = $urandom_range(2, 6);
            for (int k = 0; k < ops; k++) begin
                w = 3'($urandom);
                bus.f_miso = w;
                cyc(4);
                checks++;
                if (bus.h_miso !== w[m_sel]) begin
                    failures++; $display("FAIL rnd_miso f=%0d k=%0d: got %b want %b", f, k, bus.h_miso, w[m_sel]);
                end
                if ($urandom_range(0, 1) == 0) begin
                    r = 2'($urandom_range(0, 3));
                    strobe(r);
                    if (r < 2'd3) begin
                        m_pend = 1'b1;
                        m_pend_sel = r;
                    end
                    checks++;
                    if ({bus.sel_pending, bus.sel_active, bus.sel_err} !== {m_pend, m_sel, (r == 2'd3)}) begin
                        failures++; $display("FAIL rnd_req f=%0d k=%0d: got %b want %b", f, k,
                                             {bus.sel_pending, bus.sel_active, bus.sel_err}, {m_pend, m_sel, (r == 2'd3)});
                    end
                end else begin
                    sck_pulse();
                    if (w[0] != w[1]) begin
                        m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
                        m_flag = 1'b1;
                    end
                end
            end
            bus.h_cs_n = 1'b1;
            cyc(5);
            if (m_pend) m_sel = m_pend_sel;
            m_pend = 1'b0;
            checks++;
            if ({bus.h_miso, bus.sel_pending, bus.sel_active, bus.mis_cnt, bus.mis_flag} !== {1'b1, 1'b0, m_sel, exp_cnt(), exp_flag()}) begin
                failures++; $display("FAIL rnd_end f=%0d: got %b want %b", f,
                                     {bus.h_miso, bus.sel_pending, bus.sel_active, bus.mis_cnt, bus.mis_flag},
                                     {1'b1, 1'b0, m_sel, exp_cnt(), exp_flag()});
            end
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        m_sel           = 2'd0;
        m_pend          = 1'b0;
        m_pend_sel      = 2'd0;
        m_cnt           = 0;
        m_flag          = 1'b0;
        bus.f_miso      = 3'b111;
        bus.h_cs_n      = 1'b1;
        bus.h_sck       = 1'b0;
        bus.sel_req     = 2'd0;
        bus.sel_req_vld = 1'b0;
        rst_n           = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        test_reset();
        test_idle_select();
        test_deferred_select();
        test_bad_index();
        test_edge_collision();
        test_mismatch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
